// File: rtl/delay_pipe_pkg.sv
// Shared helpers for the delay_pipe elastic register pipeline.
package delay_pipe_pkg;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One pipeline slot: a valid flag plus its data word.
module delay_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Load wins over clear; data is left stale when the slot empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/delay_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshakes and bubble collapse.
module delay_pipe
    import delay_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter bit          INVERT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] clear;
    logic [WIDTH-1:0] d   [DEPTH];
    logic [WIDTH-1:0] din [DEPTH];
    logic             take;
    logic             xfer;

    // A stage moves when the slot ahead is empty or is itself moving.
    always_comb begin
        adv          = '0;
        adv[DEPTH-1] = v[DEPTH-1] & out_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign in_ready  = rst_n & ~flush & (~v[0] | adv[0]);
    assign take      = in_valid & in_ready;
    assign xfer      = v[DEPTH-1] & out_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Flush empties every slot and suppresses loads so data registers stay put.
    always_comb begin
        load     = '0;
        clear    = '0;
        load[0]  = take;
        clear[0] = flush | (adv[0] & ~take);
        din[0]   = INVERT ? ~in_data : in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            load[i]  = adv[i-1] & ~flush;
            clear[i] = flush | (adv[i] & ~adv[i-1]);
            din[i]   = d[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        delay_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .clear (clear[i]),
            .din   (din[i]),
            .valid (v[i]),
            .data  (d[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(take) - CW'(xfer);
        end
    end

endmodule
